// File: rtl/cmp_pkg.sv
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types and sizing helpers for the digit-serial comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_cmp.sv
// ============================================================================
// Module      : digit_cmp
// Description : Combinational unsigned compare of one DIGIT-bit digit pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
// ============================================================================
// Module      : seq_comparator
// Description : Digit-serial MSB-first magnitude comparator with early exit.
//               Optional two's-complement mode via SEQ_CMP_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             Gt,
    output logic             Eq,
    output logic             Lt
);

    localparam int                 c_NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int                 c_CNT_W = calc_cnt_w(c_NDIG);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_NDIG - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    cmp_state_t         r_state;
    cmp_state_t         w_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [c_CNT_W-1:0] r_cnt;
    cmp_result_t        r_res;
    logic [WIDTH-1:0]   w_bias;
    logic               w_gt;
    logic               w_lt;
    logic               w_accept;
    logic               w_decide;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef SEQ_CMP_SIGNED_EN
    localparam logic [WIDTH-1:0] c_MSB = WIDTH'(1) << (WIDTH - 1);
    assign w_bias = signed_mode ? c_MSB : '0;
`else
    assign w_bias = '0;
`endif

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a  (r_sa[WIDTH-1 -: DIGIT]),
        .b  (r_sb[WIDTH-1 -: DIGIT]),
        .gt (w_gt),
        .lt (w_lt)
    );

    assign w_accept = start && (r_state != RUN);
    assign w_decide = (r_state == RUN) && (w_gt || w_lt || (r_cnt == c_LAST));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_decide) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else if (w_accept) begin
            r_sa  <= a ^ w_bias;
            r_sb  <= b ^ w_bias;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            if (w_decide) begin
                r_res.gt <= w_gt;
                r_res.eq <= !(w_gt || w_lt);
                r_res.lt <= w_lt;
            end else begin
                r_sa  <= r_sa << DIGIT;
                r_sb  <= r_sb << DIGIT;
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Gt   = r_res.gt;
    assign Eq   = r_res.eq;
    assign Lt   = r_res.lt;

endmodule

`default_nettype wire

// File: tb/tb_seq_comparator.sv
// ============================================================================
// Module      : tb_seq_comparator
// Description : Scoreboard bench for seq_comparator (WIDTH=8, DIGIT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_comparator;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int ND = W / D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
`ifdef SEQ_CMP_SIGNED_EN
    logic         signed_mode = 1'b0;
`endif
    logic         busy, done, Gt, Eq, Lt;

    seq_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef SEQ_CMP_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .Gt          (Gt),
        .Eq          (Eq),
        .Lt          (Lt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         done_cyc;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: result from integer compare, k from the first differing digit.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sm, output logic [2:0] res, output int k);
        int xi, yi, ux, uy, bias;
        xi   = sm ? int'($signed(x)) : int'(x);
        yi   = sm ? int'($signed(y)) : int'(y);
        res  = (xi > yi) ? 3'b100 : ((xi == yi) ? 3'b010 : 3'b001);
        bias = sm ? (1 << (W - 1)) : 0;
        ux   = int'(x) ^ bias;
        uy   = int'(y) ^ bias;
        k    = ND;
        for (int i = 0; i < ND; i++) begin
            if (((ux >> (W - D * (i + 1))) % (1 << D)) != ((uy >> (W - D * (i + 1))) % (1 << D))) begin
                k = i + 1;
                break;
            end
        end
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sm, output int k);
        logic [2:0] res;
        model(x, y, sm, res, k);
        a     = x;
        b     = y;
        start = 1'b1;
`ifdef SEQ_CMP_SIGNED_EN
        signed_mode = sm;
`endif
        q.push_back('{res, cyc + 1 + k});
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
`ifdef SEQ_CMP_SIGNED_EN
        signed_mode = 1'($urandom);
`endif
    endtask

    task automatic wait_done(output int nbusy);
        logic found;
        found = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        chk("done_seen", {31'b0, found}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: done=1 with no pending request (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_gel", {29'b0, Gt, Eq, Lt}, {29'b0, e.res});
                chk("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    initial begin
        int k, nb;
        logic [W-1:0] x, y;
        logic sm;

        repeat (2) @(negedge clk);
        chk("in_reset_outputs", {27'b0, busy, done, Gt, Eq, Lt}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", {27'b0, busy, done, Gt, Eq, Lt}, 32'd0);

        start_op(8'hA5, 8'hA5, 1'b0, k);
        wait_done(nb);
        chk("eq_busy_cycles", nb, 32'd4);
        @(negedge clk);

        start_op(8'h80, 8'h7F, 1'b0, k);
        wait_done(nb);
        chk("unsigned_msb_busy", nb, 32'd1);
        @(negedge clk);
`ifdef SEQ_CMP_SIGNED_EN
        start_op(8'h80, 8'h7F, 1'b1, k);
        wait_done(nb);
        chk("signed_msb_busy", nb, 32'd1);
        chk("signed_msb_lt", {31'b0, Lt}, 32'd1);
        @(negedge clk);
`endif

        start_op(8'h12, 8'h13, 1'b0, k);
        wait_done(nb);
        chk("lt_busy_cycles", nb, 32'd4);
        start_op(8'h13, 8'h12, 1'b0, k);
        wait_done(nb);
        chk("b2b_busy_cycles", nb, 32'd4);
        @(negedge clk);

        // Second start while busy must be ignored.
        start_op(8'h00, 8'h01, 1'b0, k);
        a     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", {31'b0, busy}, 32'd1);
        wait_done(nb);
        chk("ignored_start_lt", {31'b0, Lt}, 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        start_op(8'h00, 8'h01, 1'b0, k);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {27'b0, busy, done, Gt, Eq, Lt}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle", {30'b0, busy, done}, 32'd0);
        start_op(8'h5A, 8'h5B, 1'b0, k);
        wait_done(nb);
        chk("post_reset_busy", nb, 32'd4);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ W'($urandom_range(1, 3));
                2:       y = x ^ W'($urandom_range(1, 15));
                default: y = W'($urandom);
            endcase
`ifdef SEQ_CMP_SIGNED_EN
            sm = 1'($urandom);
`else
            sm = 1'b0;
`endif
            start_op(x, y, sm, k);
            wait_done(nb);
            chk("rand_busy_cycles", nb, k);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, digit-serial magnitude comparator. It is the sequential successor to the combinational 2-bit comparator. It captures two WIDTH-bit operands on a start pulse and compares them MSB-first, DIGIT bits per cycle, stopping as soon as a digit differs. Results are registered on the same Gt/Eq/Lt outputs and held until the next accepted start. It sits wherever wide compares would break timing or where compare latency may be traded for area.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled on rising clk.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- signed_mode  in  1  two's-complement compare. Present only with SEQ_CMP_SIGNED_EN.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse: Gt/Eq/Lt have just updated.
- Gt  out  1  a > b (last result).
- Eq  out  1  a == b (last result).
- Lt  out  1  a < b (last result).

## Operation
- NDIG = WIDTH/DIGIT. Digit counter width is $clog2(NDIG), minimum 1.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DONE when the current digits differ or the last digit is reached.
  - DONE -> RUN on start, otherwise -> IDLE.
- start is accepted only in IDLE or DONE. start while busy=1 is ignored; the operation in flight is not disturbed.
- On acceptance:
  - a and b are loaded into shift registers sa/sb.
  - The digit counter is cleared.
  - Gt/Eq/Lt keep their previous values.
- Each RUN cycle compares sa[WIDTH-1 -: DIGIT] against sb[WIDTH-1 -: DIGIT] as unsigned values.
  - If they differ: register Gt/Lt accordingly, Eq=0, go to DONE.
  - If they are equal and this is digit NDIG-1: register Eq=1, Gt=Lt=0, go to DONE.
  - Otherwise: shift sa and sb left by DIGIT and increment the counter.
- After the first result, exactly one of Gt/Eq/Lt is 1 at all times.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, Gt=0, Eq=0, Lt=0 ("no result yet").
  - sa, sb and the counter are 0.
- Let start be accepted at edge E0. busy is 1 from E0 until the deciding edge Ek, where k is the 1-based index of the first differing digit, or NDIG if the operands are equal.
- At Ek: Gt/Eq/Lt update, done=1 for exactly one cycle, busy=0.
- Latency is k cycles. Worst case is NDIG; best case is 1.
- Back-to-back: start asserted during the done cycle is accepted. There are no bubbles between operations.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). No done pulse is emitted. The operation in flight is lost.
- Operands a/b may change freely after the accepting edge.

## Configuration
- SEQ_CMP_SIGNED_EN defined:
  - The signed_mode port exists.
  - When signed_mode=1 at acceptance, the MSB of both a and b is inverted on capture (offset-binary bias), giving a two's-complement compare with identical latency.
  - signed_mode is sampled only at acceptance.
- SEQ_CMP_SIGNED_EN undefined: the port is absent and the compare is always unsigned.

## Structure
- Shared package cmp_pkg holds:
  - The state typedef (IDLE, RUN, DONE).
  - A result typedef: the {Gt,Eq,Lt} triple.
  - Localparam helpers for NDIG and the counter width.
- Sub-module digit_cmp: combinational DIGIT-bit unsigned compare with outputs gt and lt. The top instantiates it once on the shift-register MSB digits.

## Test plan
All scenarios use WIDTH=8, DIGIT=2.
- Reset, then idle for 3 cycles -> busy=0, done=0, Gt=Eq=Lt=0.
- a=8'hA5, b=8'hA5, one start pulse -> done after 4 cycles, Eq=1, Gt=Lt=0; busy high for exactly 4 cycles.
- a=8'h80, b=8'h7F, unsigned -> done after 1 cycle, Gt=1. With SEQ_CMP_SIGNED_EN and signed_mode=1 -> Lt=1, also after 1 cycle.
- a=8'h12, b=8'h13 -> done after 4 cycles, Lt=1. Then start asserted in the done cycle with a=8'h13, b=8'h12 -> Gt=1 after 4 more cycles, with no idle cycle between operations.
- Start with a=8'h00, b=8'h01. Re-pulse start at cycle 2 with a=8'hFF -> the second pulse is ignored; done at cycle 4 with Lt=1.
- Start with a=8'h00, b=8'h01. Assert rst_n=0 at cycle 2 -> busy, done and the results clear immediately; no done pulse follows. A fresh start after release behaves normally.
